// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: EX/MEM forwarding selects, a per-register busy
// scoreboard for long-latency writes, and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_we,
    input  logic              id_long,
    input  logic              flush,
    input  logic              alu_reg_we,
    input  logic [AW-1:0]     alu_reg_waddr,
    input  logic              mem_reg_we,
    input  logic [AW-1:0]     mem_reg_waddr,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    output logic              stall_req,
    output logic              issue,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [NREG-1:0]   busy_vec,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       live1, live2;
    logic [2:0] res1, res2;
    logic       waw_stall;
    logic       long_set;

    // Per-source evaluation, returns {stall, sel[1:0]}. A busy register takes
    // priority over short-latency matches; a same-cycle writeback releases it
    // and the write-first register file supplies the value (select 00).
    function automatic logic [2:0] eval_src(
        input logic            live,
        input logic [AW-1:0]   rs,
        input logic [NREG-1:0] busy,
        input logic            wbv,
        input logic [AW-1:0]   wbr,
        input logic            exwe,
        input logic [AW-1:0]   exwa,
        input logic            memwe,
        input logic [AW-1:0]   memwa
    );
        logic [2:0] r;
        r = 3'b000;
        if (live) begin
            if (busy[rs]) begin
                r[2] = ~(wbv && (wbr == rs));
            end else if (exwe && (exwa == rs)) begin
                if (FWD_EN) r[1:0] = 2'b01;
                else        r[2]   = 1'b1;
            end else if (memwe && (memwa == rs)) begin
                if (FWD_EN) r[1:0] = 2'b10;
                else        r[2]   = 1'b1;
            end
        end
        return r;
    endfunction

    // Hazard detection, forwarding selects and issue; all held at 0 in reset.
    always_comb begin
        live1 = id_valid && id_rs1_used && (id_rs1 != '0);
        live2 = id_valid && id_rs2_used && (id_rs2 != '0);
        res1  = eval_src(live1, id_rs1, busy_q, wb_valid, wb_rd,
                         alu_reg_we, alu_reg_waddr, mem_reg_we, mem_reg_waddr);
        res2  = eval_src(live2, id_rs2, busy_q, wb_valid, wb_rd,
                         alu_reg_we, alu_reg_waddr, mem_reg_we, mem_reg_waddr);
        // Keeps at most one long write outstanding per register.
        waw_stall = id_valid && id_we && id_long && (id_rd != '0) && busy_q[id_rd]
                    && !(wb_valid && (wb_rd == id_rd));
        stall_req   = rst && (res1[2] || res2[2] || waw_stall);
        fwd_rs1_sel = rst ? res1[1:0] : 2'b00;
        fwd_rs2_sel = rst ? res2[1:0] : 2'b00;
        issue       = rst && id_valid && !stall_req && !flush;
    end

    // Scoreboard next state: clear on writeback, then set on long issue so set wins.
    always_comb begin
        busy_d   = busy_q;
        long_set = issue && id_we && id_long && (id_rd != '0);
        if (wb_valid && (wb_rd != '0)) busy_d[wb_rd] = 1'b0;
        if (long_set) busy_d[id_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Stall counter next state, saturating at all-ones; flushed cycles are not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_req && !flush && (cnt_q != CntMax)) cnt_d = cnt_q + CntOne;
    end

    // State registers; reset forgets every outstanding long op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec  = busy_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: two instances share stimulus, one forwarding (32-bit counter),
// one stall-only (4-bit counter).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_long, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        alu_reg_we, mem_reg_we, wb_valid;
    logic [4:0]  alu_reg_waddr, mem_reg_waddr, wb_rd;

    logic        a_stall, a_issue, b_stall, b_issue;
    logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
    logic [31:0] a_busy, b_busy;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(32), .AW(5), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_we(id_we), .id_long(id_long), .flush(flush),
        .alu_reg_we(alu_reg_we), .alu_reg_waddr(alu_reg_waddr),
        .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_req(a_stall), .issue(a_issue),
        .fwd_rs1_sel(a_sel1), .fwd_rs2_sel(a_sel2), .busy_vec(a_busy), .stall_cnt(a_cnt)
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .FWD_EN(1'b0), .CNT_W(4)) u_stl (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_we(id_we), .id_long(id_long), .flush(flush),
        .alu_reg_we(alu_reg_we), .alu_reg_waddr(alu_reg_waddr),
        .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_req(b_stall), .issue(b_issue),
        .fwd_rs1_sel(b_sel1), .fwd_rs2_sel(b_sel2), .busy_vec(b_busy), .stall_cnt(b_cnt)
    );

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_we = 0; id_long = 0; flush = 0;
        alu_reg_we = 0; alu_reg_waddr = 0; mem_reg_we = 0; mem_reg_waddr = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        id_valid = 1; id_we = 1; id_long = 1; id_rd = rd;
    endtask

    task automatic read_rs1(input logic [4:0] rs);
        idle();
        id_valid = 1; id_rs1 = rs; id_rs1_used = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        id_valid = 1;
        #3;
        checks++; if (a_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", a_busy); end
        checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", a_cnt); end
        checks++; if (a_issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", a_issue); end
        next_cycle();
        next_cycle();
        idle();
        rst = 1;
    endtask

    task automatic test_reset_midrun();
        issue_long(5'd3);
        #1;
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL mid_issue3: got %b want 1", a_issue); end
        next_cycle();
        issue_long(5'd7);
        next_cycle();
        read_rs1(5'd3);
        #1;
        checks++; if (a_busy !== 32'h88) begin errors++; $display("FAIL mid_busy: got %h want 88", a_busy); end
        checks++; if (b_busy !== 32'h88) begin errors++; $display("FAIL mid_busy_b: got %h want 88", b_busy); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL mid_stall[%0d]: got %b want 1", i, a_stall); end
            next_cycle();
        end
        checks++; if (a_cnt !== 32'd7) begin errors++; $display("FAIL mid_cnt: got %0d want 7", a_cnt); end
        checks++; if (b_cnt !== 4'd7) begin errors++; $display("FAIL mid_cnt_b: got %0d want 7", b_cnt); end
        rst = 0;
        #1;
        checks++; if (a_busy !== 32'h0) begin errors++; $display("FAIL async_busy: got %h want 0", a_busy); end
        checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL async_cnt: got %0d want 0", a_cnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL async_stall: got %b want 0", a_stall); end
        checks++; if (a_issue !== 1'b0) begin errors++; $display("FAIL async_issue: got %b want 0", a_issue); end
        next_cycle();
        rst = 1;
        idle();
        next_cycle();
    endtask

    task automatic test_fwd_priority();
        idle();
        id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rs1_used = 1; id_rs2_used = 1;
        alu_reg_we = 1; alu_reg_waddr = 5; mem_reg_we = 1; mem_reg_waddr = 5;
        #1;
        checks++; if (a_sel1 !== 2'b01) begin errors++; $display("FAIL prio_sel1: got %b want 01", a_sel1); end
        checks++; if (a_sel2 !== 2'b01) begin errors++; $display("FAIL prio_sel2: got %b want 01", a_sel2); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b want 0", a_stall); end
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL prio_issue: got %b want 1", a_issue); end
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL nofwd_stall: got %b want 1", b_stall); end
        checks++; if (b_sel1 !== 2'b00) begin errors++; $display("FAIL nofwd_sel1: got %b want 00", b_sel1); end
        alu_reg_waddr = 6;
        #1;
        checks++; if (a_sel1 !== 2'b10) begin errors++; $display("FAIL mem_sel1: got %b want 10", a_sel1); end
        checks++; if (a_sel2 !== 2'b10) begin errors++; $display("FAIL mem_sel2: got %b want 10", a_sel2); end
        id_rs1_used = 0;
        #1;
        checks++; if (a_sel1 !== 2'b00) begin errors++; $display("FAIL unused_sel1: got %b want 00", a_sel1); end
        checks++; if (a_sel2 !== 2'b10) begin errors++; $display("FAIL unused_sel2: got %b want 10", a_sel2); end
        idle();
        next_cycle();
    endtask

    task automatic test_stall_mode_x0();
        idle();
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; mem_reg_we = 1; mem_reg_waddr = 7;
        #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL stallmode_x7: got %b want 1", b_stall); end
        checks++; if (a_sel2 !== 2'b10) begin errors++; $display("FAIL fwdmode_x7: got %b want 10", a_sel2); end
        id_rs2 = 0; mem_reg_waddr = 0;
        #1;
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL stallmode_x0: got %b want 0", b_stall); end
        checks++; if (a_sel2 !== 2'b00) begin errors++; $display("FAIL fwdmode_x0: got %b want 00", a_sel2); end
        idle();
        next_cycle();
    endtask

    task automatic test_long_raw();
        issue_long(5'd3);
        #1;
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL raw_issue: got %b want 1", a_issue); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            read_rs1(5'd3);
            if (i == 1) begin alu_reg_we = 1; alu_reg_waddr = 3; end
            #1;
            checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL raw_stall[%0d]: got %b want 1", i, a_stall); end
            checks++; if (a_sel1 !== 2'b00) begin errors++; $display("FAIL raw_sel[%0d]: got %b want 00", i, a_sel1); end
            next_cycle();
        end
        read_rs1(5'd3);
        wb_valid = 1; wb_rd = 3;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", a_stall); end
        checks++; if (a_sel1 !== 2'b00) begin errors++; $display("FAIL raw_release_sel: got %b want 00", a_sel1); end
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL raw_release_issue: got %b want 1", a_issue); end
        next_cycle();
        idle();
        #1;
        checks++; if (a_busy[3] !== 1'b0) begin errors++; $display("FAIL raw_busy3: got %b want 0", a_busy[3]); end
        next_cycle();
    endtask

    task automatic test_waw_set_wins();
        issue_long(5'd9);
        next_cycle();
        issue_long(5'd9);
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", a_stall); end
        checks++; if (a_issue !== 1'b0) begin errors++; $display("FAIL waw_issue: got %b want 0", a_issue); end
        next_cycle();
        wb_valid = 1; wb_rd = 9;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL waw_release: got %b want 0", a_stall); end
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL waw_reissue: got %b want 1", a_issue); end
        next_cycle();
        idle();
        wb_valid = 1; wb_rd = 9;
        #1;
        checks++; if (a_busy !== 32'h200) begin errors++; $display("FAIL set_wins: got %h want 200", a_busy); end
        next_cycle();
        idle();
        #1;
        checks++; if (a_busy !== 32'h0) begin errors++; $display("FAIL wb_clear9: got %h want 0", a_busy); end
        next_cycle();
    endtask

    task automatic test_saturation_flush();
        rst = 0;
        #2;
        rst = 1;
        next_cycle();
        issue_long(5'd4);
        next_cycle();
        read_rs1(5'd4);
        for (int i = 0; i < 20; i++) next_cycle();
        checks++; if (b_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", b_cnt); end
        checks++; if (a_cnt !== 32'd20) begin errors++; $display("FAIL wide_cnt: got %0d want 20", a_cnt); end
        flush = 1;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", a_stall); end
        checks++; if (a_issue !== 1'b0) begin errors++; $display("FAIL flush_issue: got %b want 0", a_issue); end
        next_cycle();
        checks++; if (a_cnt !== 32'd20) begin errors++; $display("FAIL flush_nocount: got %0d want 20", a_cnt); end
        id_rs1_used = 0;
        #1;
        checks++; if (a_issue !== 1'b0) begin errors++; $display("FAIL flush_nostall_issue: got %b want 0", a_issue); end
        flush = 0;
        #1;
        checks++; if (a_issue !== 1'b1) begin errors++; $display("FAIL noflush_issue: got %b want 1", a_issue); end
        idle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_fwd_priority();
        test_stall_mode_x0();
        test_long_raw();
        test_waw_set_wins();
        test_saturation_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
